// File: rtl/ddrphy_lanectrl_pkg.sv
// Shared encodings for the DDR PHY lane delay-line sequencer: command ops, completion codes,
// sequencer states and the pause-window length.
package ddrphy_lanectrl_pkg;

  localparam logic [1:0] OpMove = 2'b00;
  localparam logic [1:0] OpLoad = 2'b01;

  localparam logic [1:0] ErrOk     = 2'b00;
  localparam logic [1:0] ErrBadCmd = 2'b01;
  localparam logic [1:0] ErrSat    = 2'b10;
  localparam logic [1:0] ErrOor    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StAct,
    StGap,
    StPost,
    StDone
  } state_e;

  function automatic int unsigned pause_cyc(input int unsigned ext);
    return 32'd2 + 32'd2 * ext;
  endfunction

endpackage

// File: rtl/ddrphy_tap_tracker.sv
// Per-lane RX/TX tap-position counters. Saturate at 0 and all-ones; the last single-step change
// can be reverted once when the PHY reports the delay line out of range.
module ddrphy_tap_tracker #(
  parameter int unsigned NumCnt  = 2,
  parameter int unsigned TapW    = 8,
  parameter int unsigned InitVal = 1,
  parameter int unsigned IdxW    = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     inc_i,
  input  logic                     dec_i,
  input  logic                     load_i,
  input  logic                     undo_i,
  input  logic [IdxW-1:0]          idx_i,
  output logic [NumCnt*TapW-1:0]   pos_o,
  output logic                     at_max_o,
  output logic                     at_min_o
);

  logic [TapW-1:0] pos_q [NumCnt];
  logic [TapW-1:0] pos_d [NumCnt];
  logic [TapW-1:0] prev_q, prev_d;
  logic [TapW-1:0] cur, nxt;
  logic            upd;

  always_comb begin
    cur = '0;
    for (int i = 0; i < NumCnt; i++) begin
      if (idx_i == IdxW'(i)) cur = pos_q[i];
    end
  end

  assign at_max_o = (cur == {TapW{1'b1}});
  assign at_min_o = (cur == '0);

  always_comb begin
    nxt    = cur;
    upd    = 1'b1;
    prev_d = prev_q;
    if (inc_i && !at_max_o) begin
      nxt = cur + 1'b1;
    end else if (dec_i && !at_min_o) begin
      nxt = cur - 1'b1;
    end else if (load_i) begin
      nxt = TapW'(InitVal);
    end else if (undo_i) begin
      nxt = prev_q;
    end else begin
      upd = 1'b0;
    end
    // Remember the pre-change value so an out-of-range report can roll it back.
    if (upd && !undo_i) prev_d = cur;
    for (int i = 0; i < NumCnt; i++) begin
      pos_d[i] = (upd && (idx_i == IdxW'(i))) ? nxt : pos_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCnt; i++) pos_q[i] <= TapW'(InitVal);
      prev_q <= TapW'(InitVal);
    end else begin
      for (int i = 0; i < NumCnt; i++) pos_q[i] <= pos_d[i];
      prev_q <= prev_d;
    end
  end

  for (genvar g = 0; g < NumCnt; g++) begin : g_flat
    assign pos_o[g*TapW +: TapW] = pos_q[g];
  end

endmodule

// File: rtl/ddrphy_lane_dly_seq.sv
// Fabric-side sequencer driving per-lane LANECTRL delay-line strobes inside an HS_IO_CLK_PAUSE
// window, with RX/TX tap tracking, saturation and out-of-range abort.
module ddrphy_lane_dly_seq
  import ddrphy_lanectrl_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 1,
  parameter int unsigned TAP_W          = 8,
  parameter int unsigned DELAY_VAL_INIT = 1,
  parameter int unsigned PAUSE_EXT      = 0,
  parameter int unsigned MOVE_GAP       = 4,
  localparam int unsigned LANE_IDX_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                         FAB_CLK,
  input  logic                         RESET,
  input  logic                         CMD_VALID,
  output logic                         CMD_READY,
  input  logic [LANE_IDX_W-1:0]        CMD_LANE,
  input  logic [1:0]                   CMD_OP,
  input  logic                         CMD_SEL,
  input  logic                         CMD_DIR,
  input  logic [7:0]                   CMD_COUNT,
  output logic                         DONE,
  output logic                         ERR,
  output logic [1:0]                   ERR_CODE,
  input  logic [NUM_LANES-1:0]         RX_OOR,
  input  logic [NUM_LANES-1:0]         TX_OOR,
  output logic [NUM_LANES-1:0]         HS_IO_CLK_PAUSE,
  output logic [NUM_LANES-1:0]         DELAY_LINE_SEL,
  output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
  output logic [2*NUM_LANES*TAP_W-1:0] TAP_POS
);

  localparam int unsigned PauseCyc  = pause_cyc(PAUSE_EXT);
  localparam logic [15:0] PauseLast = 16'(PauseCyc - 1);
  localparam logic [15:0] GapLast   = 16'(MOVE_GAP - 1);
  localparam int unsigned IdxW      = LANE_IDX_W + 1;

  state_e                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [7:0]              rem_q, rem_d;
  logic [LANE_IDX_W-1:0]   lane_q, lane_d;
  logic [1:0]              op_q, op_d;
  logic [1:0]              err_q, err_d;
  logic                    sel_q, sel_d;
  logic                    dir_q, dir_d;
  logic [NUM_LANES-1:0]    line_sel_q, line_sel_d;
  logic [NUM_LANES-1:0]    line_dir_q, line_dir_d;
  logic [NUM_LANES-1:0]    lane_oh;
  logic                    at_max, at_min, sat, oor_sel, bad_cmd;
  logic                    move_fire, load_fire, gap_end;

  always_comb begin
    lane_oh = '0;
    for (int i = 0; i < NUM_LANES; i++) lane_oh[i] = (lane_q == LANE_IDX_W'(i));
  end

  assign sat     = dir_q ? at_max : at_min;
  assign oor_sel = |(lane_oh & (sel_q ? TX_OOR : RX_OOR));
  assign gap_end = (state_q == StGap) && (cnt_q == '0);
  assign bad_cmd = (32'(CMD_LANE) >= NUM_LANES) || CMD_OP[1];

  always_ff @(posedge FAB_CLK) begin
    if (RESET) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      lane_q     <= '0;
      op_q       <= OpMove;
      err_q      <= ErrOk;
      sel_q      <= 1'b0;
      dir_q      <= 1'b0;
      line_sel_q <= '0;
      line_dir_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      lane_q     <= lane_d;
      op_q       <= op_d;
      err_q      <= err_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      line_sel_q <= line_sel_d;
      line_dir_q <= line_dir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    lane_d     = lane_q;
    op_d       = op_q;
    err_d      = err_q;
    sel_d      = sel_q;
    dir_d      = dir_q;
    line_sel_d = line_sel_q;
    line_dir_d = line_dir_q;
    unique case (state_q)
      StIdle: begin
        if (CMD_VALID) begin
          lane_d = CMD_LANE;
          op_d   = CMD_OP;
          sel_d  = CMD_SEL;
          dir_d  = CMD_DIR;
          rem_d  = (CMD_OP == OpMove) ? CMD_COUNT : 8'd0;
          err_d  = ErrOk;
          if (bad_cmd) begin
            err_d   = ErrBadCmd;
            state_d = StDone;
          end else if (CMD_OP == OpMove && CMD_COUNT == 8'd0) begin
            state_d = StDone;
          end else begin
            state_d = StPre;
            cnt_d   = PauseLast;
            for (int i = 0; i < NUM_LANES; i++) begin
              if (CMD_LANE == LANE_IDX_W'(i)) begin
                line_sel_d[i] = CMD_SEL;
                line_dir_d[i] = CMD_DIR;
              end
            end
          end
        end
      end
      StPre: begin
        if (cnt_q == '0) state_d = StAct;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StAct: begin
        if (op_q == OpMove && sat) begin
          err_d   = ErrSat;
          state_d = StPost;
          cnt_d   = PauseLast;
        end else begin
          if (op_q == OpMove) rem_d = rem_q - 1'b1;
          state_d = StGap;
          cnt_d   = GapLast;
        end
      end
      StGap: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (oor_sel) begin
          err_d   = ErrOor;
          state_d = StPost;
          cnt_d   = PauseLast;
        end else if (rem_q != '0) begin
          state_d = StAct;
        end else begin
          state_d = StPost;
          cnt_d   = PauseLast;
        end
      end
      StPost: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    CMD_READY       = (state_q == StIdle) && !RESET;
    move_fire       = (state_q == StAct) && (op_q == OpMove) && !sat;
    load_fire       = (state_q == StAct) && (op_q == OpLoad);
    HS_IO_CLK_PAUSE = '0;
    if (state_q inside {StPre, StAct, StGap, StPost}) HS_IO_CLK_PAUSE = lane_oh;
    DELAY_LINE_MOVE = move_fire ? lane_oh : '0;
    DELAY_LINE_LOAD = load_fire ? lane_oh : '0;
    DONE            = (state_q == StDone);
    ERR_CODE        = DONE ? err_q : ErrOk;
    ERR             = DONE && (err_q != ErrOk);
  end

  assign DELAY_LINE_SEL       = line_sel_q;
  assign DELAY_LINE_DIRECTION = line_dir_q;

  ddrphy_tap_tracker #(
    .NumCnt  (2 * NUM_LANES),
    .TapW    (TAP_W),
    .InitVal (DELAY_VAL_INIT),
    .IdxW    (IdxW)
  ) u_tap_tracker (
    .clk_i    (FAB_CLK),
    .rst_i    (RESET),
    .inc_i    (move_fire && dir_q),
    .dec_i    (move_fire && !dir_q),
    .load_i   (load_fire),
    .undo_i   (gap_end && oor_sel),
    .idx_i    ({lane_q, sel_q}),
    .pos_o    (TAP_POS),
    .at_max_o (at_max),
    .at_min_o (at_min)
  );

endmodule
